ex_dispatch: RTL and testbench

Issue stage between the per-thread ID/EX registers and the shared ALUs. It consumes the decoded per-thread operation bundles from decode, which carry the opcode handle `oh`, operands, register addresses, pc and the raw instruction. Each cycle it grants at most `NUM_ALUS` of the `NUM_Threads` candidates to ALU slots in round-robin order. It buffers every denied operation in a one-entry per-thread pending slot and drives the per-thread `hold` back to decode and fetch until that operation has issued.

---
 rtl/ex_dispatch.sv | 212 +++++++++++++++++++++
 tb/tb_ex_dispatch.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_dispatch.sv
// ----------------------------------------------------------------------------
// ex_dispatch
//
// Issue stage between the per-thread ID/EX registers and the shared ALUs.
// Every cycle up to NUM_ALUS thread candidates are granted to ALU slots in
// round-robin order starting at ptr_q. A denied operation is parked in a
// one-entry per-thread pending slot, and hold[t] stalls decode/fetch until
// that operation has issued.
//
// Parameters:
//   NUM_Threads  hardware threads (>= 2)
//   NUM_ALUS     ALU issue slots, 1 <= NUM_ALUS <= NUM_Threads
//   TID_W        thread-id width
//
// Ports:
//   clk                        clock
//   rst                        asynchronous active-low reset
//   oh_in[t]          in  7    decoded op handle, 0 = no operation
//   op1_in/op2_in[t]  in  32   operands
//   ins_in/pc_in[t]   in  32   raw instruction and pc
//   rd/rs1/rs2_in[t]  in  5    register addresses
//   hold[t]           out 1    combinational stall to decode and fetch
//   alu_valid[s]      out 1    slot s carries an operation (registered)
//   alu_tid[s]        out      owning thread of slot s
//   alu_oh..alu_rs2   out      issued bundle (zero when slot invalid)
//   stall_cnt[t]      out 32   saturating hold-cycle counter, present only
//                              when EX_DISPATCH_STATS_EN is defined
// ----------------------------------------------------------------------------
module ex_dispatch #(
    parameter int NUM_Threads = 4,
    parameter int NUM_ALUS    = 3,
    parameter int TID_W       = $clog2(NUM_Threads)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       oh_in   [NUM_Threads],
    input  logic [31:0]      op1_in  [NUM_Threads],
    input  logic [31:0]      op2_in  [NUM_Threads],
    input  logic [31:0]      ins_in  [NUM_Threads],
    input  logic [31:0]      pc_in   [NUM_Threads],
    input  logic [4:0]       rd_in   [NUM_Threads],
    input  logic [4:0]       rs1_in  [NUM_Threads],
    input  logic [4:0]       rs2_in  [NUM_Threads],
    output logic             hold    [NUM_Threads],
    output logic             alu_valid [NUM_ALUS],
    output logic [TID_W-1:0] alu_tid   [NUM_ALUS],
    output logic [6:0]       alu_oh    [NUM_ALUS],
    output logic [31:0]      alu_op1   [NUM_ALUS],
    output logic [31:0]      alu_op2   [NUM_ALUS],
    output logic [31:0]      alu_ins   [NUM_ALUS],
    output logic [31:0]      alu_pc    [NUM_ALUS],
    output logic [4:0]       alu_rd    [NUM_ALUS],
    output logic [4:0]       alu_rs1   [NUM_ALUS],
    output logic [4:0]       alu_rs2   [NUM_ALUS]
`ifdef EX_DISPATCH_STATS_EN
    ,
    output logic [31:0]      stall_cnt [NUM_Threads]
`endif
);

    localparam int SLOT_W = (NUM_ALUS > 1) ? $clog2(NUM_ALUS) : 1;

    typedef struct packed {
        logic [6:0]  oh;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] ins;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } bundle_t;

    // Round-robin pointer: advances every cycle out of reset, even when idle.
    logic [TID_W-1:0] ptr_q, ptr_d;

    // Pending slot per thread.
    logic [NUM_Threads-1:0] pend_v_q, pend_v_d;
    bundle_t                pend_q [NUM_Threads];
    bundle_t                pend_d [NUM_Threads];

    // Candidate selection and arbitration results.
    logic [NUM_Threads-1:0] cand_v;
    logic [NUM_Threads-1:0] grant;
    logic [NUM_Threads-1:0] hold_w;
    bundle_t                live_b [NUM_Threads];
    bundle_t                cand_b [NUM_Threads];

    // Issue registers.
    logic [NUM_ALUS-1:0]    alu_valid_q, alu_valid_d;
    logic [TID_W-1:0]       alu_tid_q [NUM_ALUS];
    logic [TID_W-1:0]       alu_tid_d [NUM_ALUS];
    bundle_t                alu_b_q   [NUM_ALUS];
    bundle_t                alu_b_d   [NUM_ALUS];

    assign ptr_d = (ptr_q == TID_W'(NUM_Threads - 1)) ? '0 : ptr_q + 1'b1;

    // ------------------------------------------------------------------
    // Per-thread candidate, hold and pending-slot update
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_Threads; gi++) begin : g_thread
        assign live_b[gi] = '{oh:  oh_in[gi],  op1: op1_in[gi], op2: op2_in[gi],
                              ins: ins_in[gi], pc:  pc_in[gi],  rd:  rd_in[gi],
                              rs1: rs1_in[gi], rs2: rs2_in[gi]};

        // A parked operation always takes priority; the live input is
        // expected to be zero while hold is high and is ignored regardless.
        assign cand_v[gi] = pend_v_q[gi] | (oh_in[gi] != 7'd0);
        assign cand_b[gi] = pend_v_q[gi] ? pend_q[gi] : live_b[gi];

        assign hold_w[gi] = (cand_v[gi] & ~grant[gi]) | (pend_v_q[gi] & ~grant[gi]);
        assign hold[gi]   = hold_w[gi];

        // Granted -> slot empties; denied (live or pending) -> slot full.
        assign pend_v_d[gi] = grant[gi] ? 1'b0 : cand_v[gi];
        // A denied pending candidate reloads itself, so it stays unchanged.
        assign pend_d[gi]   = (cand_v[gi] & ~grant[gi]) ? cand_b[gi] : pend_q[gi];
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration: k-th candidate from ptr gets slot k
    // ------------------------------------------------------------------
    always_comb begin
        int cnt;
        int idx;
        cnt   = 0;
        idx   = 0;
        grant = '0;
        alu_valid_d = '0;
        for (int s = 0; s < NUM_ALUS; s++) begin
            alu_tid_d[s] = '0;
            alu_b_d[s]   = '0;
        end
        for (int i = 0; i < NUM_Threads; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_Threads) begin
                idx = idx - NUM_Threads;
            end
            if (cand_v[idx[TID_W-1:0]] && (cnt < NUM_ALUS)) begin
                grant[idx[TID_W-1:0]]          = 1'b1;
                alu_valid_d[cnt[SLOT_W-1:0]]   = 1'b1;
                alu_tid_d[cnt[SLOT_W-1:0]]     = idx[TID_W-1:0];
                alu_b_d[cnt[SLOT_W-1:0]]       = cand_b[idx[TID_W-1:0]];
                cnt = cnt + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            pend_v_q    <= '0;
            alu_valid_q <= '0;
            for (int t = 0; t < NUM_Threads; t++) begin
                pend_q[t] <= '0;
            end
            for (int s = 0; s < NUM_ALUS; s++) begin
                alu_tid_q[s] <= '0;
                alu_b_q[s]   <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            pend_v_q    <= pend_v_d;
            alu_valid_q <= alu_valid_d;
            for (int t = 0; t < NUM_Threads; t++) begin
                pend_q[t] <= pend_d[t];
            end
            for (int s = 0; s < NUM_ALUS; s++) begin
                alu_tid_q[s] <= alu_tid_d[s];
                alu_b_q[s]   <= alu_b_d[s];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_ALUS; gi++) begin : g_slot
        assign alu_valid[gi] = alu_valid_q[gi];
        assign alu_tid[gi]   = alu_tid_q[gi];
        assign alu_oh[gi]    = alu_b_q[gi].oh;
        assign alu_op1[gi]   = alu_b_q[gi].op1;
        assign alu_op2[gi]   = alu_b_q[gi].op2;
        assign alu_ins[gi]   = alu_b_q[gi].ins;
        assign alu_pc[gi]    = alu_b_q[gi].pc;
        assign alu_rd[gi]    = alu_b_q[gi].rd;
        assign alu_rs1[gi]   = alu_b_q[gi].rs1;
        assign alu_rs2[gi]   = alu_b_q[gi].rs2;
    end

`ifdef EX_DISPATCH_STATS_EN
    // ------------------------------------------------------------------
    // Saturating per-thread hold-cycle counters
    // ------------------------------------------------------------------
    logic [NUM_Threads-1:0][31:0] stall_cnt_q, stall_cnt_d;

    for (genvar gi = 0; gi < NUM_Threads; gi++) begin : g_stats
        assign stall_cnt_d[gi] = (hold_w[gi] && (stall_cnt_q[gi] != 32'hFFFF_FFFF))
                                 ? stall_cnt_q[gi] + 32'd1 : stall_cnt_q[gi];
        assign stall_cnt[gi]   = stall_cnt_q[gi];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_ex_dispatch.sv
// ----------------------------------------------------------------------------
// tb_ex_dispatch
//
// Directed testbench for ex_dispatch (4 threads, 3 ALUs). Each scenario task
// drives stimulus and compares DUT outputs against hand-derived values.
// ----------------------------------------------------------------------------
module tb_ex_dispatch;

    logic        clk;
    logic        rst;
    logic [6:0]  oh_in  [4];
    logic [31:0] op1_in [4];
    logic [31:0] op2_in [4];
    logic [31:0] ins_in [4];
    logic [31:0] pc_in  [4];
    logic [4:0]  rd_in  [4];
    logic [4:0]  rs1_in [4];
    logic [4:0]  rs2_in [4];
    logic        hold   [4];
    logic        alu_valid [3];
    logic [1:0]  alu_tid   [3];
    logic [6:0]  alu_oh    [3];
    logic [31:0] alu_op1   [3];
    logic [31:0] alu_op2   [3];
    logic [31:0] alu_ins   [3];
    logic [31:0] alu_pc    [3];
    logic [4:0]  alu_rd    [3];
    logic [4:0]  alu_rs1   [3];
    logic [4:0]  alu_rs2   [3];
`ifdef EX_DISPATCH_STATS_EN
    logic [31:0] stall_cnt [4];
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    ex_dispatch #(.NUM_Threads(4), .NUM_ALUS(3)) dut (
        .clk(clk), .rst(rst),
        .oh_in(oh_in), .op1_in(op1_in), .op2_in(op2_in), .ins_in(ins_in),
        .pc_in(pc_in), .rd_in(rd_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
        .hold(hold),
        .alu_valid(alu_valid), .alu_tid(alu_tid), .alu_oh(alu_oh),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ins(alu_ins),
        .alu_pc(alu_pc), .alu_rd(alu_rd), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2)
`ifdef EX_DISPATCH_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] base_pc(input int t);
        return 32'h1000 * (t + 1);
    endfunction

    task automatic clear_thread(input int t);
        oh_in[t] = '0; op1_in[t] = '0; op2_in[t] = '0; ins_in[t] = '0;
        pc_in[t] = '0; rd_in[t]  = '0; rs1_in[t] = '0; rs2_in[t] = '0;
    endtask

    task automatic clear_inputs;
        for (int t = 0; t < 4; t++) clear_thread(t);
    endtask

    task automatic set_op(input int t, input logic [6:0] oh, input logic [31:0] pc);
        oh_in[t]  = oh;
        pc_in[t]  = pc;
        op1_in[t] = pc ^ 32'hA5A5_0000;
        op2_in[t] = pc + 32'd7;
        ins_in[t] = pc | 32'h13;
        rd_in[t]  = 5'(t + 1);
        rs1_in[t] = 5'(t + 9);
        rs2_in[t] = 5'(t + 17);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at posedge+1 with ptr=0 for the current cycle.
    task automatic do_reset;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b0;
        #3;
        for (int t = 0; t < 4; t++) begin
            total_cnt++;
            if (hold[t] !== 1'b0) $display("FAIL reset_hold[%0d]: got %b expected 0", t, hold[t]);
            else pass_cnt++;
        end
        for (int s = 0; s < 3; s++) begin
            total_cnt++;
            if (alu_valid[s] !== 1'b0 || alu_tid[s] !== 2'd0 || alu_pc[s] !== 32'd0)
                $display("FAIL reset_slot[%0d]: got valid=%b tid=%0d pc=%0h expected 0/0/0",
                         s, alu_valid[s], alu_tid[s], alu_pc[s]);
            else pass_cnt++;
        end
        $display("test_reset done");
    endtask

    task automatic test_partial;
        do_reset();
        set_op(0, 7'd19, 32'h100);
        set_op(2, 7'd28, 32'h200);
        #1;
        for (int t = 0; t < 4; t++) begin
            total_cnt++;
            if (hold[t] !== 1'b0) $display("FAIL partial_hold[%0d]: got %b expected 0", t, hold[t]);
            else pass_cnt++;
        end
        step();
        clear_inputs();
        total_cnt++;
        if (alu_valid[0] !== 1'b1 || alu_tid[0] !== 2'd0 || alu_oh[0] !== 7'd19 ||
            alu_pc[0] !== 32'h100 || alu_op1[0] !== 32'hA5A5_0100 || alu_rd[0] !== 5'd1)
            $display("FAIL partial_slot0: got v=%b tid=%0d oh=%0d pc=%0h op1=%0h rd=%0d expected 1/0/19/100/a5a50100/1",
                     alu_valid[0], alu_tid[0], alu_oh[0], alu_pc[0], alu_op1[0], alu_rd[0]);
        else pass_cnt++;
        total_cnt++;
        if (alu_valid[1] !== 1'b1 || alu_tid[1] !== 2'd2 || alu_oh[1] !== 7'd28 ||
            alu_pc[1] !== 32'h200 || alu_op2[1] !== 32'h207 || alu_rs2[1] !== 5'd19)
            $display("FAIL partial_slot1: got v=%b tid=%0d oh=%0d pc=%0h op2=%0h rs2=%0d expected 1/2/28/200/207/19",
                     alu_valid[1], alu_tid[1], alu_oh[1], alu_pc[1], alu_op2[1], alu_rs2[1]);
        else pass_cnt++;
        total_cnt++;
        if (alu_valid[2] !== 1'b0 || alu_oh[2] !== 7'd0 || alu_pc[2] !== 32'd0)
            $display("FAIL partial_slot2: got v=%b oh=%0d pc=%0h expected 0/0/0",
                     alu_valid[2], alu_oh[2], alu_pc[2]);
        else pass_cnt++;
        $display("test_partial done");
    endtask

    task automatic test_overload;
        do_reset();
        for (int t = 0; t < 4; t++) set_op(t, 7'(t + 1), 32'(t * 16));
        #1;
        total_cnt++;
        if (hold[0] !== 1'b0 || hold[1] !== 1'b0 || hold[2] !== 1'b0 || hold[3] !== 1'b1)
            $display("FAIL overload_hold_c0: got %b%b%b%b expected 1000 (t3..t0)",
                     hold[3], hold[2], hold[1], hold[0]);
        else pass_cnt++;
        step();
        // ptr=1: threads 0-2 advance, thread 3 held so decode presents zero
        clear_thread(3);
        for (int t = 0; t < 3; t++) set_op(t, 7'(t + 5), 32'(t * 16 + 4));
        #1;
        total_cnt++;
        if (dut.pend_v_q[3] !== 1'b1) $display("FAIL overload_pend_v3: got %b expected 1", dut.pend_v_q[3]);
        else pass_cnt++;
        total_cnt++;
        if (hold[0] !== 1'b1 || hold[1] !== 1'b0 || hold[2] !== 1'b0 || hold[3] !== 1'b0)
            $display("FAIL overload_hold_c1: got %b%b%b%b expected 0001 (t3..t0)",
                     hold[3], hold[2], hold[1], hold[0]);
        else pass_cnt++;
        total_cnt++;
        if (alu_tid[0] !== 2'd0 || alu_tid[1] !== 2'd1 || alu_tid[2] !== 2'd2 ||
            alu_pc[2] !== 32'd32 || alu_valid[2] !== 1'b1)
            $display("FAIL overload_issue_c0: got tids %0d,%0d,%0d pc2=%0h v2=%b expected 0,1,2 pc2=20 v2=1",
                     alu_tid[0], alu_tid[1], alu_tid[2], alu_pc[2], alu_valid[2]);
        else pass_cnt++;
        step();
        clear_inputs();
        #1;
        total_cnt++;
        if (alu_tid[0] !== 2'd1 || alu_pc[0] !== 32'd20 || alu_tid[1] !== 2'd2 ||
            alu_pc[1] !== 32'd36 || alu_tid[2] !== 2'd3 || alu_oh[2] !== 7'd4 || alu_pc[2] !== 32'd48)
            $display("FAIL overload_issue_c1: got %0d:%0h %0d:%0h %0d:%0d:%0h expected 1:14 2:24 3:4:30",
                     alu_tid[0], alu_pc[0], alu_tid[1], alu_pc[1], alu_tid[2], alu_oh[2], alu_pc[2]);
        else pass_cnt++;
        total_cnt++;
        if (hold[0] !== 1'b0) $display("FAIL overload_hold0_grant: got %b expected 0", hold[0]);
        else pass_cnt++;
`ifdef EX_DISPATCH_STATS_EN
        total_cnt++;
        if (stall_cnt[3] !== 32'd1 || stall_cnt[0] !== 32'd1)
            $display("FAIL stats_overload: got t3=%0d t0=%0d expected 1/1", stall_cnt[3], stall_cnt[0]);
        else pass_cnt++;
`endif
        step();
        total_cnt++;
        if (alu_valid[0] !== 1'b1 || alu_tid[0] !== 2'd0 || alu_oh[0] !== 7'd5 ||
            alu_pc[0] !== 32'd4 || alu_valid[1] !== 1'b0)
            $display("FAIL overload_issue_c2: got v=%b tid=%0d oh=%0d pc=%0h v1=%b expected 1/0/5/4/0",
                     alu_valid[0], alu_tid[0], alu_oh[0], alu_pc[0], alu_valid[1]);
        else pass_cnt++;
        $display("test_overload done");
    endtask

    task automatic test_reset_mid;
        do_reset();
        for (int t = 0; t < 4; t++) set_op(t, 7'(t + 1), 32'(t * 16));
        step();
        clear_inputs();
        #1;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (dut.pend_v_q !== 4'b0000) $display("FAIL midreset_pend_v: got %b expected 0000", dut.pend_v_q);
        else pass_cnt++;
        total_cnt++;
        if (hold[3] !== 1'b0) $display("FAIL midreset_hold3: got %b expected 0", hold[3]);
        else pass_cnt++;
        for (int s = 0; s < 3; s++) begin
            total_cnt++;
            if (alu_valid[s] !== 1'b0 || alu_tid[s] !== 2'd0 || alu_oh[s] !== 7'd0 || alu_pc[s] !== 32'd0)
                $display("FAIL midreset_slot[%0d]: got v=%b tid=%0d oh=%0d pc=%0h expected 0/0/0/0",
                         s, alu_valid[s], alu_tid[s], alu_oh[s], alu_pc[s]);
            else pass_cnt++;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int t = 0; t < 4; t++) set_op(t, 7'(t + 9), 32'(t * 16 + 8));
        #1;
        total_cnt++;
        if (hold[3] !== 1'b1 || hold[0] !== 1'b0)
            $display("FAIL midreset_first_arb_hold: got t3=%b t0=%b expected 1/0", hold[3], hold[0]);
        else pass_cnt++;
        step();
        clear_inputs();
        total_cnt++;
        if (alu_tid[0] !== 2'd0 || alu_pc[0] !== 32'd8 || alu_valid[0] !== 1'b1)
            $display("FAIL midreset_first_grant: got tid=%0d pc=%0h v=%b expected 0/8/1",
                     alu_tid[0], alu_pc[0], alu_valid[0]);
        else pass_cnt++;
        $display("test_reset_mid done");
    endtask

    task automatic test_idle;
        logic [1:0] exp_ptr [5];
        exp_ptr[0] = 2'd0; exp_ptr[1] = 2'd1; exp_ptr[2] = 2'd2; exp_ptr[3] = 2'd3; exp_ptr[4] = 2'd0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            #1;
            total_cnt++;
            if (dut.ptr_q !== exp_ptr[c]) $display("FAIL idle_ptr c%0d: got %0d expected %0d", c, dut.ptr_q, exp_ptr[c]);
            else pass_cnt++;
            total_cnt++;
            if (hold[0] | hold[1] | hold[2] | hold[3] | alu_valid[0] | alu_valid[1] | alu_valid[2])
                $display("FAIL idle_quiet c%0d: got hold=%b%b%b%b valid=%b%b%b expected all 0", c,
                         hold[3], hold[2], hold[1], hold[0], alu_valid[2], alu_valid[1], alu_valid[0]);
            else pass_cnt++;
            $display("idle cycle %0d ptr=%0d", c, dut.ptr_q);
            step();
        end
        #1;
        total_cnt++;
        if (dut.ptr_q !== 2'd1) $display("FAIL idle_ptr_end: got %0d expected 1", dut.ptr_q);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int issued  [4];
        int fetched [4];
        int denied  [4];
        logic prev_h [4];
        logic snap   [4];
        int consec;
        int nvalid;
        int exp_d;
        int tt;
        consec = 0;
        do_reset();
        for (int t = 0; t < 4; t++) begin
            issued[t] = 0; denied[t] = 0; prev_h[t] = 1'b0;
            set_op(t, 7'(28 + t), base_pc(t));
            fetched[t] = 1;
        end
        #1;
        for (int c = 0; c < 8; c++) begin
            exp_d = (c + 3) % 4;
            for (int t = 0; t < 4; t++) begin
                total_cnt++;
                if (hold[t] !== (t == exp_d))
                    $display("FAIL b2b_hold c%0d t%0d: got %b expected %b", c, t, hold[t], (t == exp_d));
                else pass_cnt++;
                if (hold[t] === 1'b1) begin
                    denied[t]++;
                    if (prev_h[t] === 1'b1) consec++;
                end
                prev_h[t] = hold[t];
                snap[t]   = hold[t];
            end
            step();
            nvalid = 0;
            for (int s = 0; s < 3; s++) begin
                if (alu_valid[s] === 1'b1) begin
                    nvalid++;
                    tt = int'(alu_tid[s]);
                    total_cnt++;
                    if (alu_pc[s] !== base_pc(tt) + 32'(4 * issued[tt]))
                        $display("FAIL b2b_pc c%0d slot%0d t%0d: got %0h expected %0h",
                                 c, s, tt, alu_pc[s], base_pc(tt) + 32'(4 * issued[tt]));
                    else pass_cnt++;
                    issued[tt]++;
                end
            end
            total_cnt++;
            if (nvalid != 3) $display("FAIL b2b_slots c%0d: got %0d valid expected 3", c, nvalid);
            else pass_cnt++;
            $display("b2b cycle %0d denied=t%0d issued=%0d", c, exp_d, nvalid);
            for (int t = 0; t < 4; t++) begin
                if (snap[t]) clear_thread(t);
                else begin
                    set_op(t, 7'(28 + t), base_pc(t) + 32'(4 * fetched[t]));
                    fetched[t]++;
                end
            end
            #1;
        end
        for (int t = 0; t < 4; t++) begin
            total_cnt++;
            if (denied[t] != 2 || issued[t] != 6)
                $display("FAIL b2b_totals t%0d: got denied=%0d issued=%0d expected 2/6", t, denied[t], issued[t]);
            else pass_cnt++;
        end
        total_cnt++;
        if (consec != 0) $display("FAIL b2b_consecutive: got %0d expected 0", consec);
        else pass_cnt++;
        clear_inputs();
    endtask

`ifdef EX_DISPATCH_STATS_EN
    task automatic test_stats_saturate;
        do_reset();
        force dut.stall_cnt_q[1] = 32'hFFFF_FFFF;
        step();
        release dut.stall_cnt_q[1];
        // ptr=1 now; thread 1 is denied when ptr=2
        for (int t = 0; t < 4; t++) set_op(t, 7'd40, 32'(t * 4));
        for (int c = 0; c < 4; c++) step();
        clear_inputs();
        total_cnt++;
        if (stall_cnt[1] !== 32'hFFFF_FFFF)
            $display("FAIL stats_saturate: got %0h expected ffffffff", stall_cnt[1]);
        else pass_cnt++;
        $display("test_stats_saturate done");
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_partial();
        test_overload();
        test_reset_mid();
        test_idle();
        test_back_to_back();
`ifdef EX_DISPATCH_STATS_EN
        test_stats_saturate();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
